// File: rtl/vga_pixel_fetch_if.sv
// Pixel fetch bus: ROM read port (fetcher is master of the ROM) plus the
// control and pixel-pop signals towards the VGA pipeline.
interface vga_pixel_fetch_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
);
  logic             en_in;
  logic             frame_start_in;
  logic [AW-1:0]    rom_addr_out;
  logic             rom_rd_en_out;
  logic [WIDTH-1:0] rom_dat_in;
  logic             pix_rd_in;
  logic [WIDTH-1:0] pix_dat_out;
  logic             pix_vld_out;
  logic             underflow_out;

  // Fetcher side
  modport slave (
    input  en_in, frame_start_in, rom_dat_in, pix_rd_in,
    output rom_addr_out, rom_rd_en_out, pix_dat_out, pix_vld_out, underflow_out
  );

  // Environment side (ROM model, pixel stage, timing control)
  modport master (
    output en_in, frame_start_in, rom_dat_in, pix_rd_in,
    input  rom_addr_out, rom_rd_en_out, pix_dat_out, pix_vld_out, underflow_out
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// VGA pixel fetcher: issues sequential ROM reads under a credit limit so the
// first-word-fall-through FIFO can never overflow, and hands words to the
// pixel stage in strict address order.
module vga_pixel_fetch #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  vga_pixel_fetch_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] LIMIT    = SW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);

  logic [AW-1:0]    r_rom_addr;
  logic             r_rd_en;
  logic [AW-1:0]    r_next_addr;
  logic             r_rd_en_d;
  logic [1:0]       r_outst;
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_underflow;

  logic [SW-1:0]    w_credit;
  logic             w_empty;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_uf_evt;
  logic [WIDTH-1:0] w_pix_dat;

  // Credit/handshake decode; a frame start masks every state-changing event
  always_comb begin
    w_credit = {1'b0, r_count} + {{(SW-2){1'b0}}, r_outst};
    w_empty  = (r_count == {CW{1'b0}});
    w_issue  = bus.en_in & ~bus.frame_start_in & (w_credit < LIMIT);
    w_push   = r_rd_en_d & ~bus.frame_start_in;
    w_pop    = bus.pix_rd_in & ~w_empty & ~bus.frame_start_in;
    w_uf_evt = bus.pix_rd_in & w_empty & ~bus.frame_start_in;
  end

  // Head word; forced to zero while the FIFO is empty
  always_comb begin
    w_pix_dat = {WIDTH{1'b0}};
    if (w_empty) begin
      w_pix_dat = {WIDTH{1'b0}};
    end else begin
      w_pix_dat = r_mem[r_rptr];
    end
  end

  // ROM request issue, return tracking and outstanding-request counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rom_addr  <= {AW{1'b0}};
      r_rd_en     <= 1'b0;
      r_next_addr <= {AW{1'b0}};
      r_rd_en_d   <= 1'b0;
      r_outst     <= 2'd0;
    end else if (bus.frame_start_in) begin
      // drop both in-flight stages so stale words are never pushed
      r_rd_en     <= 1'b0;
      r_rd_en_d   <= 1'b0;
      r_next_addr <= {AW{1'b0}};
      r_outst     <= 2'd0;
    end else begin
      r_rd_en   <= w_issue;
      r_rd_en_d <= r_rd_en;
      if (w_issue) begin
        r_rom_addr  <= r_next_addr;
        r_next_addr <= (r_next_addr == LAST_ADR) ? {AW{1'b0}} : r_next_addr + AW'(1);
      end
      case ({w_issue, w_push})
        2'b10:   r_outst <= r_outst + 2'd1;
        2'b01:   r_outst <= r_outst - 2'd1;
        default: r_outst <= r_outst;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else if (bus.frame_start_in) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage write; contents need no reset because the head is masked when empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.rom_dat_in;
    end
  end

  // Sticky underflow flag, cleared only by reset or frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underflow <= 1'b0;
    end else if (bus.frame_start_in) begin
      r_underflow <= 1'b0;
    end else if (w_uf_evt) begin
      r_underflow <= 1'b1;
    end
  end

  assign bus.rom_addr_out  = r_rom_addr;
  assign bus.rom_rd_en_out = r_rd_en;
  assign bus.pix_dat_out   = w_pix_dat;
  assign bus.pix_vld_out   = ~w_empty;
  assign bus.underflow_out = r_underflow;
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch with a registered ROM model holding
// mem[i] = i + 0x10.
module tb_vga_pixel_fetch;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [7:0] rom [16];

  vga_pixel_fetch_if #(.WIDTH(8), .AW(4)) bus ();

  vga_pixel_fetch #(.WIDTH(8), .DEPTH(16), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered ROM: data for an enabled read appears one cycle later
  always @(posedge clk) begin
    if (bus.rom_rd_en_out) bus.rom_dat_in <= rom[bus.rom_addr_out];
  end

  // a push into a full FIFO must never happen
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(dut.w_push && dut.r_count == 3'd4)) else begin
        $display("FAIL fifo_overflow: push with count=%0d required <4", dut.r_count);
        bad++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    total++; if (bus.rom_rd_en_out !== 1'b0) begin bad++; $display("FAIL rst_rd_en: got %b req 0", bus.rom_rd_en_out); end
    total++; if (bus.rom_addr_out !== 4'd0) begin bad++; $display("FAIL rst_addr: got %h req 0", bus.rom_addr_out); end
    total++; if (bus.pix_vld_out !== 1'b0) begin bad++; $display("FAIL rst_vld: got %b req 0", bus.pix_vld_out); end
    total++; if (bus.pix_dat_out !== 8'h00) begin bad++; $display("FAIL rst_dat: got %h req 00", bus.pix_dat_out); end
    total++; if (bus.underflow_out !== 1'b0) begin bad++; $display("FAIL rst_uf: got %b req 0", bus.underflow_out); end
  endtask

  // release reset with en_in high and no pops; expect four reads then stall
  task automatic test_fill(input string tag);
    int reads;
    reads = 0;
    rst = 1'b0; bus.en_in = 1'b1; bus.frame_start_in = 1'b0; bus.pix_rd_in = 1'b0;
    tick(); // cycle 1
    total++; if (bus.rom_rd_en_out !== 1'b1 || bus.rom_addr_out !== 4'd0) begin bad++; $display("FAIL %s_first_read: got en=%b addr=%h req en=1 addr=0", tag, bus.rom_rd_en_out, bus.rom_addr_out); end
    reads = 1;
    tick(); // cycle 2
    total++; if (bus.pix_vld_out !== 1'b0) begin bad++; $display("FAIL %s_vld_early: got %b req 0", tag, bus.pix_vld_out); end
    total++; if (bus.rom_rd_en_out !== 1'b1 || bus.rom_addr_out !== 4'd1) begin bad++; $display("FAIL %s_read1: got en=%b addr=%h req en=1 addr=1", tag, bus.rom_rd_en_out, bus.rom_addr_out); end
    reads = 2;
    tick(); // cycle 3
    total++; if (bus.pix_vld_out !== 1'b1 || bus.pix_dat_out !== 8'h10) begin bad++; $display("FAIL %s_first_word: got vld=%b dat=%h req vld=1 dat=10", tag, bus.pix_vld_out, bus.pix_dat_out); end
    for (int c = 0; c < 8; c++) begin
      if (bus.rom_rd_en_out === 1'b1) begin
        total++; if (bus.rom_addr_out !== 4'(reads)) begin bad++; $display("FAIL %s_read_addr: got %h req %h", tag, bus.rom_addr_out, 4'(reads)); end
        reads++;
      end
      tick();
    end
    total++; if (reads !== 4) begin bad++; $display("FAIL %s_read_count: got %0d req 4", tag, reads); end
    total++; if (bus.rom_rd_en_out !== 1'b0) begin bad++; $display("FAIL %s_stall: got en=%b req 0", tag, bus.rom_rd_en_out); end
    total++; if (bus.pix_dat_out !== 8'h10) begin bad++; $display("FAIL %s_head: got %h req 10", tag, bus.pix_dat_out); end
  endtask

  // continuous pops from a full FIFO across the address wrap
  task automatic test_stream();
    logic [7:0] exp;
    bus.pix_rd_in = 1'b1;
    for (int i = 0; i < 17; i++) begin
      exp = 8'(16 + (i % 16));
      total++; if (bus.pix_vld_out !== 1'b1) begin bad++; $display("FAIL stream_gap%0d: got vld=%b req 1", i, bus.pix_vld_out); end
      total++; if (bus.pix_dat_out !== exp) begin bad++; $display("FAIL stream_word%0d: got %h req %h", i, bus.pix_dat_out, exp); end
      tick();
    end
    bus.pix_rd_in = 1'b0;
    total++; if (bus.underflow_out !== 1'b0) begin bad++; $display("FAIL stream_uf: got %b req 0", bus.underflow_out); end
  endtask

  // single pop from a full FIFO while fetching is enabled
  task automatic test_full_pop();
    for (int c = 0; c < 8; c++) tick();
    total++; if (bus.pix_vld_out !== 1'b1 || bus.pix_dat_out !== 8'h11) begin bad++; $display("FAIL full_head: got vld=%b dat=%h req vld=1 dat=11", bus.pix_vld_out, bus.pix_dat_out); end
    total++; if (bus.rom_rd_en_out !== 1'b0) begin bad++; $display("FAIL full_idle: got en=%b req 0", bus.rom_rd_en_out); end
    bus.pix_rd_in = 1'b1;
    tick();
    bus.pix_rd_in = 1'b0;
    total++; if (bus.rom_rd_en_out !== 1'b0 || bus.pix_dat_out !== 8'h12) begin bad++; $display("FAIL full_pop: got en=%b dat=%h req en=0 dat=12", bus.rom_rd_en_out, bus.pix_dat_out); end
    tick();
    total++; if (bus.rom_rd_en_out !== 1'b1 || bus.rom_addr_out !== 4'd5) begin bad++; $display("FAIL full_refetch: got en=%b addr=%h req en=1 addr=5", bus.rom_rd_en_out, bus.rom_addr_out); end
    tick();
    total++; if (bus.rom_rd_en_out !== 1'b0) begin bad++; $display("FAIL full_single_read: got en=%b req 0", bus.rom_rd_en_out); end
    tick(); tick();
    total++; if (bus.pix_dat_out !== 8'h12) begin bad++; $display("FAIL full_head_after: got %h req 12", bus.pix_dat_out); end
  endtask

  // pop while empty sets the sticky flag; frame start clears it
  task automatic test_underflow();
    bus.en_in = 1'b0; bus.frame_start_in = 1'b1;
    tick();
    bus.frame_start_in = 1'b0;
    total++; if (bus.pix_vld_out !== 1'b0 || bus.underflow_out !== 1'b0 || bus.rom_rd_en_out !== 1'b0) begin bad++; $display("FAIL uf_flush: got vld=%b uf=%b en=%b req 0 0 0", bus.pix_vld_out, bus.underflow_out, bus.rom_rd_en_out); end
    bus.pix_rd_in = 1'b1;
    tick();
    bus.pix_rd_in = 1'b0;
    total++; if (bus.underflow_out !== 1'b1 || bus.pix_vld_out !== 1'b0) begin bad++; $display("FAIL uf_set: got uf=%b vld=%b req uf=1 vld=0", bus.underflow_out, bus.pix_vld_out); end
    bus.en_in = 1'b1;
    tick(); tick(); tick(); tick();
    total++; if (bus.pix_vld_out !== 1'b1 || bus.pix_dat_out !== 8'h10) begin bad++; $display("FAIL uf_no_ptr_move: got vld=%b dat=%h req vld=1 dat=10", bus.pix_vld_out, bus.pix_dat_out); end
    bus.pix_rd_in = 1'b1;
    tick();
    bus.pix_rd_in = 1'b0;
    total++; if (bus.underflow_out !== 1'b1 || bus.pix_dat_out !== 8'h11) begin bad++; $display("FAIL uf_sticky: got uf=%b dat=%h req uf=1 dat=11", bus.underflow_out, bus.pix_dat_out); end
    bus.frame_start_in = 1'b1;
    tick();
    bus.frame_start_in = 1'b0;
    total++; if (bus.underflow_out !== 1'b0 || bus.pix_vld_out !== 1'b0) begin bad++; $display("FAIL uf_clear: got uf=%b vld=%b req 0 0", bus.underflow_out, bus.pix_vld_out); end
  endtask

  // frame start while reads of addr 6 and 7 are in flight
  task automatic test_frame_inflight();
    logic       found;
    logic       prev_en;
    logic [3:0] prev_addr;
    found = 1'b0; prev_en = 1'b0; prev_addr = 4'd0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (bus.rom_rd_en_out === 1'b1 && bus.rom_addr_out === 4'd7 && prev_en === 1'b1 && prev_addr === 4'd6) begin
        found = 1'b1;
      end else begin
        bus.pix_rd_in = bus.pix_vld_out;
        prev_en = bus.rom_rd_en_out;
        prev_addr = bus.rom_addr_out;
        tick();
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL fs_setup_timeout: got found=%b req 1", found); end
    bus.frame_start_in = 1'b1; bus.pix_rd_in = 1'b1;
    tick();
    bus.frame_start_in = 1'b0; bus.pix_rd_in = 1'b0;
    total++; if (bus.pix_vld_out !== 1'b0 || bus.rom_rd_en_out !== 1'b0 || bus.underflow_out !== 1'b0) begin bad++; $display("FAIL fs_flush: got vld=%b en=%b uf=%b req 0 0 0", bus.pix_vld_out, bus.rom_rd_en_out, bus.underflow_out); end
    tick();
    total++; if (bus.rom_rd_en_out !== 1'b1 || bus.rom_addr_out !== 4'd0) begin bad++; $display("FAIL fs_restart: got en=%b addr=%h req en=1 addr=0", bus.rom_rd_en_out, bus.rom_addr_out); end
    tick(); tick();
    total++; if (bus.pix_vld_out !== 1'b1 || bus.pix_dat_out !== 8'h10) begin bad++; $display("FAIL fs_first_word: got vld=%b dat=%h req vld=1 dat=10", bus.pix_vld_out, bus.pix_dat_out); end
    bus.pix_rd_in = 1'b1;
    tick();
    bus.pix_rd_in = 1'b0;
    total++; if (bus.pix_dat_out !== 8'h11) begin bad++; $display("FAIL fs_second_word: got %h req 11", bus.pix_dat_out); end
  endtask

  // asynchronous reset between edges, then a repeat of the fill scenario
  task automatic test_async_reset();
    bus.en_in = 1'b0; bus.frame_start_in = 1'b1;
    tick();
    bus.frame_start_in = 1'b0; bus.pix_rd_in = 1'b1;
    tick();
    bus.pix_rd_in = 1'b0; bus.en_in = 1'b1;
    tick(); tick(); tick();
    total++; if (bus.pix_vld_out !== 1'b1 || bus.underflow_out !== 1'b1 || bus.rom_rd_en_out !== 1'b1 || bus.rom_addr_out !== 4'd2) begin bad++; $display("FAIL arst_pre: got vld=%b uf=%b en=%b addr=%h req 1 1 1 2", bus.pix_vld_out, bus.underflow_out, bus.rom_rd_en_out, bus.rom_addr_out); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.rom_rd_en_out !== 1'b0 || bus.rom_addr_out !== 4'd0) begin bad++; $display("FAIL arst_rom: got en=%b addr=%h req 0 0", bus.rom_rd_en_out, bus.rom_addr_out); end
    total++; if (bus.pix_vld_out !== 1'b0 || bus.pix_dat_out !== 8'h00 || bus.underflow_out !== 1'b0) begin bad++; $display("FAIL arst_pix: got vld=%b dat=%h uf=%b req 0 00 0", bus.pix_vld_out, bus.pix_dat_out, bus.underflow_out); end
    tick(); tick();
    test_fill("rerun");
  endtask

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < 16; i++) rom[i] = 8'(i + 16);
    rst = 1'b1;
    bus.en_in = 1'b0; bus.frame_start_in = 1'b0; bus.pix_rd_in = 1'b0; bus.rom_dat_in = 8'h00;
    test_reset();
    test_fill("fill");
    test_stream();
    test_full_pop();
    test_underflow();
    test_frame_inflight();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
